// File: rtl/bcd_to_dec_decoder.sv
// Registered BCD digit to one-hot decimal line decoder, with separate zero and non-BCD flags.
// Latency 1 cycle, no backpressure: a new code is sampled on every rising edge.
module bcd_to_dec_decoder #(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic w,
    input  logic x,
    input  logic y,
    input  logic z,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g,
    output logic h,
    output logic i,
    output logic zero,
    output logic invalid
);

    localparam logic [8:0] DIGIT_IDLE = {9{OUT_ACTIVE_LOW}};

    logic [3:0] code;
    logic [8:0] onehot;
    logic [8:0] digit_d, digit_q;
    logic       zero_d, zero_q;
    logic       invalid_d, invalid_q;

    assign code = {w, x, y, z};

    always_comb begin
        onehot    = 9'd0;
        zero_d    = 1'b0;
        invalid_d = 1'b0;
        case (code)
            4'd0:    zero_d     = 1'b1;
            4'd1:    onehot[0]  = 1'b1;
            4'd2:    onehot[1]  = 1'b1;
            4'd3:    onehot[2]  = 1'b1;
            4'd4:    onehot[3]  = 1'b1;
            4'd5:    onehot[4]  = 1'b1;
            4'd6:    onehot[5]  = 1'b1;
            4'd7:    onehot[6]  = 1'b1;
            4'd8:    onehot[7]  = 1'b1;
            4'd9:    onehot[8]  = 1'b1;
            default: invalid_d  = 1'b1;
        endcase
        // Polarity is folded in before the flop so the pins come straight off registers.
        digit_d = onehot ^ DIGIT_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q   <= DIGIT_IDLE;
            zero_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            digit_q   <= digit_d;
            zero_q    <= zero_d;
            invalid_q <= invalid_d;
        end
    end

    assign {i, h, g, f, e, d, c, b, a} = digit_q;
    assign zero    = zero_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_to_dec_decoder.sv
// Bench for both output polarities of bcd_to_dec_decoder against an arithmetic decode model.
module tb_bcd_to_dec_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w = 1'b0, x = 1'b0, y = 1'b0, z = 1'b0;
    logic [8:0] dh, dl;
    logic       zh, ih, zl, il;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    bcd_to_dec_decoder #(.OUT_ACTIVE_LOW(1'b0)) u_hi (
        .clk(clk), .rst(rst), .w(w), .x(x), .y(y), .z(z),
        .a(dh[0]), .b(dh[1]), .c(dh[2]), .d(dh[3]), .e(dh[4]),
        .f(dh[5]), .g(dh[6]), .h(dh[7]), .i(dh[8]),
        .zero(zh), .invalid(ih)
    );

    bcd_to_dec_decoder #(.OUT_ACTIVE_LOW(1'b1)) u_lo (
        .clk(clk), .rst(rst), .w(w), .x(x), .y(y), .z(z),
        .a(dl[0]), .b(dl[1]), .c(dl[2]), .d(dl[3]), .e(dl[4]),
        .f(dl[5]), .g(dl[6]), .h(dl[7]), .i(dl[8]),
        .zero(zl), .invalid(il)
    );

    // Reference: digit N in 1..9 lights line N (a=1 .. i=9); everything else lights none.
    function automatic logic [8:0] model_lines(input int n);
        if (n >= 1 && n <= 9) return 9'(1 << (n - 1));
        return 9'd0;
    endfunction

    task automatic check(input int n, input logic r, input string tag);
        logic [8:0] exp_d;
        logic       exp_z, exp_i;
        int         lit_hi, lit_lo;
        exp_d  = r ? 9'd0 : model_lines(n);
        exp_z  = !r && (n == 0);
        exp_i  = !r && (n > 9);
        vectors++;
        assert (dh === exp_d) else begin
            miscompares++;
            $error("FAIL %s hi_digits obs=%b exp=%b", tag, dh, exp_d);
        end
        assert (dl === ~exp_d) else begin
            miscompares++;
            $error("FAIL %s lo_digits obs=%b exp=%b", tag, dl, ~exp_d);
        end
        assert (zh === exp_z && zl === exp_z) else begin
            miscompares++;
            $error("FAIL %s zero obs=%b/%b exp=%b", tag, zh, zl, exp_z);
        end
        assert (ih === exp_i && il === exp_i) else begin
            miscompares++;
            $error("FAIL %s invalid obs=%b/%b exp=%b", tag, ih, il, exp_i);
        end
        if (!r) begin
            lit_hi = $countones(dh) + int'(zh) + int'(ih);
            lit_lo = $countones(~dl) + int'(zl) + int'(il);
            assert (lit_hi == 1 && lit_lo == 1) else begin
                miscompares++;
                $error("FAIL %s invariant obs=%0d/%0d exp=1", tag, lit_hi, lit_lo);
            end
        end
    endtask

    // Inputs change 1 time unit after an edge, and are checked 1 unit after the next edge.
    task automatic step(input int n, input logic r, input string tag);
        {w, x, y, z} = 4'(n);
        rst = r;
        @(posedge clk);
        #1;
        check(n, r, tag);
    endtask

    initial begin
        int n;
        logic r;
        step(5, 1'b1, "reset0");
        step(5, 1'b1, "reset1");
        step(5, 1'b0, "release_e");

        for (int k = 0; k < 16; k++) step(k, 1'b0, "count");

        step(9, 1'b0, "b2b_9");
        step(1, 1'b0, "b2b_1");

        step(7, 1'b0, "pre_rst_g");
        step(7, 1'b1, "mid_rst");
        step(7, 1'b0, "post_rst_g");

        step(3, 1'b0, "c_only");
        step(12, 1'b0, "twelve");
        step(0, 1'b0, "zero");

        for (int k = 0; k < 1000; k++) begin
            n = int'($urandom_range(0, 15));
            r = ($urandom_range(0, 49) == 0);
            step(n, r, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_to_dec_decoder.md
Name: bcd_to_dec_decoder

Overview:
- Registered BCD-to-decimal one-hot decoder.
- Takes a 4-bit BCD digit on discrete inputs w (MSB), x, y, z (LSB).
- Asserts exactly one of nine digit lines a..i, for digits 1..9.
- Used as a display/indicator driver stage; digit 0 and non-BCD codes are flagged separately.

Parameters:
- OUT_ACTIVE_LOW, 0, when 1 all digit lines a..i are inverted (asserted = 0); zero/invalid flags are never inverted.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- w  input  1  BCD bit 3 (MSB, weight 8).
- x  input  1  BCD bit 2 (weight 4).
- y  input  1  BCD bit 1 (weight 2).
- z  input  1  BCD bit 0 (LSB, weight 1).
- a  output  1  digit 1 line.
- b  output  1  digit 2 line.
- c  output  1  digit 3 line.
- d  output  1  digit 4 line.
- e  output  1  digit 5 line.
- f  output  1  digit 6 line.
- g  output  1  digit 7 line.
- h  output  1  digit 8 line.
- i  output  1  digit 9 line.
- zero  output  1  high when the registered code is 0000.
- invalid  output  1  high when the registered code is 1010..1111.

Behaviour:
- Input code N = {w,x,y,z}, an unsigned 4-bit value.
- Inputs are sampled on every rising clk edge; all outputs are registered.
- Latency is exactly 1 cycle from input change to output response; no combinational input-to-output path.
- Reset: while rst=1 at a rising edge, all digit lines go deasserted (0 when OUT_ACTIVE_LOW=0, 1 when =1), and zero=0, invalid=0.
- Reset has priority over input sampling; a reset mid-stream wipes the current decode, and the next non-reset edge decodes the then-present input.
- Decode table (asserted line for each N):
  - N=1 -> a
  - N=2 -> b
  - N=3 -> c
  - N=4 -> d
  - N=5 -> e
  - N=6 -> f
  - N=7 -> g
  - N=8 -> h
  - N=9 -> i
- N=0: all digit lines deasserted; zero=1, invalid=0.
- N=10..15: all digit lines deasserted; invalid=1, zero=0.
- Invariant: at most one of a..i is asserted, and (one digit line asserted) XOR zero XOR invalid is always true outside reset.
- Inputs may change every cycle; each edge decodes independently, with no hysteresis or history.
- X/Z on inputs is not required to be handled; the output is undefined.

Test Plan:
- Hold rst=1 for 2 edges with N=5 -> a..i all 0, zero=0, invalid=0; release rst -> one edge later e=1 only.
- Count N 0..15, one value per cycle, w,x,y,z with binary weights 8/4/2/1 -> per cycle, one cycle delayed:
  - N=0: zero=1.
  - N=1..9: a..i asserted in order, one-hot.
  - N=10..15: invalid=1 and all digit lines 0.
- Back-to-back change N=9 then N=1 on consecutive edges -> i=1 for one cycle, then a=1 with i=0; no cycle with two lines high.
- Assert rst while N=7 is registered (g=1) -> next edge all outputs cleared; deassert with N=7 still applied -> g=1 one edge later.
- OUT_ACTIVE_LOW=1, N=3 -> c=0, all other digit lines 1; during reset all digit lines 1; N=12 -> all digit lines 1, invalid=1.
- Random N for 1000 cycles -> compare every cycle against the delayed reference table, and check the one-hot/zero/invalid invariant.
